shift_rotate_unit: RTL and testbench
====================================

# shift_rotate_unit

Parametrised, sequential shift/rotate unit for the CPU datapath, extending the ALU's fixed 8-bit rotate-right with shift-left, logical and arithmetic shift-right, and rotate-left modes. It processes one bit position per clock behind a START/DONE handshake, so the ALU shift stage can stall on BUSY instead of carrying a wide combinational barrel. It also reports carry-out, zero, and illegal-mode flags.

## Interface
- WIDTH, 8: operand/result width in bits, ≥2.
- AMT_W, 3: width of the AMOUNT port; amounts ≥ WIDTH are legal.
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset. Low clears all state immediately.
- START  input  1  request; sampled only while idle (BUSY low).
- MODE  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101–111 are illegal.
- OPERAND  input  WIDTH  value to shift; latched on accepted START.
- AMOUNT  input  AMT_W  number of positions; latched on accepted START.
- RESULT  output  WIDTH  registered result; updates only on the DONE edge, then held.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse; RESULT and flags are valid from this cycle.
- CARRY  output  1  registered carry flag, updated with RESULT.
- ZERO  output  1  combinational (RESULT == 0).
- ILLEGAL  output  1  registered; set with DONE when MODE was 101–111, otherwise cleared with DONE.

## Operation
- Two states: IDLE and SHIFT. BUSY = (state == SHIFT).
- **Start (IDLE, START=1):** latch OPERAND into the working register, AMOUNT into the counter, and MODE; go to SHIFT.
- **START while in SHIFT:** ignored; no queueing.
- **Each SHIFT edge, one step on the working register W:**
  - SLL: W << 1, zero fill; step-out bit is W[WIDTH-1].
  - SRL: W >> 1, zero fill; step-out bit is W[0].
  - SRA: W >> 1, fill with W[WIDTH-1]; step-out bit is W[0].
  - ROR: {W[0], W[WIDTH-1:1]}.
  - ROL: {W[WIDTH-2:0], W[WIDTH-1]}.
- **Completion:**
  - If counter ≥ 2: do the step, decrement, stay in SHIFT.
  - If counter == 1: do the final step, write RESULT, assert DONE, go to IDLE.
  - If counter == 0: no step; RESULT = OPERAND, assert DONE, go to IDLE.
- **Illegal MODE:** no steps regardless of AMOUNT. RESULT = OPERAND, ILLEGAL = 1, CARRY = 0; completes on the first SHIFT edge.
- **CARRY:**
  - Shifts: the step-out bit of the last step.
  - ROR: final RESULT[WIDTH-1].
  - ROL: final RESULT[0].
  - AMOUNT = 0: 0.
- **Large amounts:** SLL/SRL with amount ≥ WIDTH give 0. SRA gives all sign bits. Rotates by k·WIDTH return OPERAND.
- **Reset (any time, including mid-operation):**
  - State → IDLE; RESULT = 0, DONE = 0, BUSY = 0, CARRY = 0, ILLEGAL = 0, so ZERO = 1.
  - The aborted operation never produces DONE.

## Timing
- START is sampled at edge 0. DONE is high for exactly the one cycle following edge max(N,1), where N is the latched AMOUNT. Illegal modes use N = 1 for timing.
- BUSY is high from edge 0 to edge max(N,1).
- DONE falls at the next edge.
- DONE is asserted while in IDLE, so a START present during the DONE cycle is accepted. Back-to-back throughput is one operation per max(N,1)+1 cycles.
- RESULT, CARRY and ILLEGAL change only on DONE edges or reset.
- Worst-case latency is 2^AMT_W − 1 cycles.

## Test plan
All scenarios use WIDTH=8, AMT_W=3.
- **Reset:** hold RESET low, toggle CLK → RESULT=0x00, DONE=0, BUSY=0, CARRY=0, ILLEGAL=0, ZERO=1.
- **ROR:** 0xB1 by 3 → BUSY high for 3 cycles; DONE at edge 3; RESULT=0x36, CARRY=0, ZERO=0.
- **SRA:** 0x90 by 2 → RESULT=0xE4, CARRY=0.
- **SLL:** 0x81 by 1 → RESULT=0x02, CARRY=1, DONE at edge 1.
- **SRL:** 0x01 by 1 → RESULT=0x00, ZERO=1, CARRY=1.
- **ROL by 0:** 0x5A by 0 → RESULT=0x5A, CARRY=0, DONE at edge 1.
- **Illegal mode:** MODE=110, 0x3C by 5 → RESULT=0x3C, ILLEGAL=1, DONE at edge 1.
- **START while busy:** ROL 0x01 by 7; pulse START with other operands at edge 3 → that START is ignored; RESULT=0x80, CARRY=0, DONE at edge 7.
- **Back-to-back:** then hold START in the DONE cycle with SRL 0x80 by 7 → accepted; RESULT=0x01, CARRY=0.
- **Reset mid-operation:** ROR 0xFF by 7; drive RESET low between edges 2 and 3, release two cycles later → outputs at reset values immediately, BUSY=0, no DONE afterwards. A new START then completes normally.

Source files
------------

// File: rtl/shift_rotate_unit.sv
// Sequential shift/rotate unit: one bit position per clock behind a start/done handshake.
// Supports SLL, SRL, SRA, ROR and ROL, with carry, zero and illegal-mode flags.
module shift_rotate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero_c,
    output logic             illegal
);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] step_w;
    logic             step_out;
    logic             step_carry;
    logic             mode_bad;

    // Single-position step of the working register for the latched mode.
    always_comb begin
        step_w     = work_q;
        step_out   = 1'b0;
        step_carry = 1'b0;
        unique case (mode_q)
            MODE_SLL: begin
                step_w     = {work_q[WIDTH-2:0], 1'b0};
                step_out   = work_q[WIDTH-1];
                step_carry = step_out;
            end
            MODE_SRL: begin
                step_w     = {1'b0, work_q[WIDTH-1:1]};
                step_out   = work_q[0];
                step_carry = step_out;
            end
            MODE_SRA: begin
                step_w     = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_out   = work_q[0];
                step_carry = step_out;
            end
            MODE_ROR: begin
                step_w     = {work_q[0], work_q[WIDTH-1:1]};
                step_carry = step_w[WIDTH-1];
            end
            MODE_ROL: begin
                step_w     = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_carry = step_w[0];
            end
            default: begin
                step_w     = work_q;
                step_carry = 1'b0;
            end
        endcase
    end

    assign mode_bad = (mode_q > MODE_ROL);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        result_d  = result_q;
        done_d    = 1'b0;
        carry_d   = carry_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = operand;
                    cnt_d   = amount;
                    mode_d  = mode;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (mode_bad || (cnt_q == '0)) begin
                    // No steps: the operand passes through unchanged.
                    result_d  = work_q;
                    carry_d   = 1'b0;
                    illegal_d = mode_bad;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == AMT_W'(1)) begin
                    work_d    = step_w;
                    result_d  = step_w;
                    carry_d   = step_carry;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    work_d = step_w;
                    cnt_d  = cnt_q - AMT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            result_q  <= result_d;
            done_q    <= done_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign busy    = (state_q == S_SHIFT);
    assign done    = done_q;
    assign carry   = carry_q;
    assign illegal = illegal_q;
    assign zero_c  = (result_q == '0);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed self-checking bench for shift_rotate_unit (WIDTH=8, AMT_W=3).
module tb_shift_rotate_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;
    localparam int          MAX_WAIT = 20;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             carry;
    logic             zero_c;
    logic             illegal;

    int tests_run;
    int tests_failed;

    shift_rotate_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .operand (operand),
        .amount  (amount),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .carry   (carry),
        .zero_c  (zero_c),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and reports the edge count to DONE and BUSY-high cycles.
    task automatic run_op(input logic [2:0] m, input logic [7:0] op, input logic [2:0] amt,
                          output int edges, output int busy_cycles);
        mode    = m;
        operand = op;
        amount  = amt;
        start   = 1'b1;
        tick();
        start       = 1'b0;
        edges       = 0;
        busy_cycles = busy ? 1 : 0;
        while (edges < MAX_WAIT) begin
            tick();
            edges++;
            if (done) break;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; mode = 3'b000; operand = 8'h00; amount = 3'd0;
        repeat (3) tick();
        tests_run++;
        if ({result, done, busy, carry, illegal, zero_c} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset: got res=%h done=%b busy=%b carry=%b ill=%b zero=%b, want 00 0 0 0 0 1",
                     result, done, busy, carry, illegal, zero_c);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ror();
        int e, b;
        run_op(3'b011, 8'hB1, 3'd3, e, b);
        tests_run++;
        if (e !== 3 || b !== 3) begin
            tests_failed++;
            $display("FAIL ror_timing: got done_edge=%0d busy_cycles=%0d, want 3 3", e, b);
        end
        tests_run++;
        if ({result, carry, zero_c, illegal} !== {8'h36, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL ror_result: got res=%h c=%b z=%b ill=%b, want 36 0 0 0", result, carry, zero_c, illegal);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || result !== 8'h36) begin
            tests_failed++;
            $display("FAIL ror_hold: got done=%b res=%h, want 0 36", done, result);
        end
    endtask

    task automatic test_sra();
        int e, b;
        run_op(3'b010, 8'h90, 3'd2, e, b);
        tests_run++;
        if (e !== 2 || result !== 8'hE4 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL sra: got edge=%0d res=%h c=%b, want 2 E4 0", e, result, carry);
        end
        tick();
    endtask

    task automatic test_sll();
        int e, b;
        run_op(3'b000, 8'h81, 3'd1, e, b);
        tests_run++;
        if (e !== 1 || result !== 8'h02 || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL sll: got edge=%0d res=%h c=%b, want 1 02 1", e, result, carry);
        end
        tick();
    endtask

    task automatic test_srl();
        int e, b;
        run_op(3'b001, 8'h01, 3'd1, e, b);
        tests_run++;
        if (result !== 8'h00 || zero_c !== 1'b1 || carry !== 1'b1) begin
            tests_failed++;
            $display("FAIL srl: got res=%h z=%b c=%b, want 00 1 1", result, zero_c, carry);
        end
        tick();
    endtask

    task automatic test_rol_zero();
        int e, b;
        run_op(3'b100, 8'h5A, 3'd0, e, b);
        tests_run++;
        if (e !== 1 || result !== 8'h5A || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL rol0: got edge=%0d res=%h c=%b, want 1 5A 0", e, result, carry);
        end
        tick();
    endtask

    task automatic test_illegal();
        int e, b;
        run_op(3'b110, 8'h3C, 3'd5, e, b);
        tests_run++;
        if (e !== 1 || result !== 8'h3C || illegal !== 1'b1 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal: got edge=%0d res=%h ill=%b c=%b, want 1 3C 1 0", e, result, illegal, carry);
        end
        tick();
    endtask

    // ROL 0x01 by 7 with a stray START at edge 3, then a back-to-back SRL.
    task automatic test_back_to_back();
        int e;
        mode = 3'b100; operand = 8'h01; amount = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        mode = 3'b001; operand = 8'hFF; amount = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h3C) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got busy=%b done=%b res=%h, want 1 0 3C", busy, done, result);
        end
        e = 3;
        while (e < MAX_WAIT) begin
            tick();
            e++;
            if (done) break;
        end
        tests_run++;
        if (e !== 7 || result !== 8'h80 || carry !== 1'b0 || illegal !== 1'b0) begin
            tests_failed++;
            $display("FAIL rol7: got edge=%0d res=%h c=%b ill=%b, want 7 80 0 0", e, result, carry, illegal);
        end
        mode = 3'b001; operand = 8'h80; amount = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
        end
        e = 0;
        while (e < MAX_WAIT) begin
            tick();
            e++;
            if (done) break;
        end
        tests_run++;
        if (e !== 7 || result !== 8'h01 || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_srl: got edge=%0d res=%h c=%b, want 7 01 0", e, result, carry);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int e, b, seen_done;
        mode = 3'b011; operand = 8'hFF; amount = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({result, done, busy, carry, illegal, zero_c} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_mid: got res=%h done=%b busy=%b c=%b ill=%b z=%b, want 00 0 0 0 0 1",
                     result, done, busy, carry, illegal, zero_c);
        end
        tick(); tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        tests_run++;
        if (seen_done !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got done_or_busy_seen=%0d, want 0", seen_done);
        end
        run_op(3'b000, 8'h03, 3'd2, e, b);
        tests_run++;
        if (e !== 2 || result !== 8'h0C || carry !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset_op: got edge=%0d res=%h c=%b, want 2 0C 0", e, result, carry);
        end
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 3'b000;
        operand = 8'h00;
        amount  = 3'd0;
        test_reset();
        test_ror();
        test_sra();
        test_sll();
        test_srl();
        test_rol_zero();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
